// File: rtl/ysyx_25040105_idu_pipe.sv
// ysyx_25040105_idu_pipe
// Registered RV32I/RV64I instruction-decode stage between the IFU and the EXU.
// The IFU presents {inst, pc} on a valid/ready channel. The decoded bundle is
// held in an output register that is backed by one skid entry. The stage also
// supports flush, flags illegal instructions and counts delivered bundles.
module ysyx_25040105_idu_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic             out_alu_src,
    output logic             out_reg_wen,
    output logic             out_jump_en,
    output logic             out_br_en,
    output logic [2:0]       out_br_type,
    output logic             out_mem_ren,
    output logic             out_mem_wen,
    output logic [2:0]       out_mem_size,
    output logic             out_ebreak,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    // ALU operation codes. New operations are appended and never renumbered.
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_AUIPC = 4'd4;
    localparam logic [3:0] ALU_LUI   = 4'd5;
    localparam logic [3:0] ALU_JAL   = 4'd6;
    localparam logic [3:0] ALU_JALR  = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_XOR   = 4'd11;
    localparam logic [3:0] ALU_OR    = 4'd12;
    localparam logic [3:0] ALU_AND   = 4'd13;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_wen;
        logic            jump_en;
        logic            br_en;
        logic [2:0]      br_type;
        logic            mem_ren;
        logic            mem_wen;
        logic [2:0]      mem_size;
        logic            ebreak;
        logic            illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;
    logic [CNT_W-1:0] count_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] shift_f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic accept;
    logic drain;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    // On RV64, inst[25] is part of the 6-bit shift amount, so it is ignored when
    // the shift encoding is checked. On RV32 it must be zero.
    assign shift_f7 = (XLEN == 64) ? {funct7[6:1], 1'b0} : funct7;

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // Decode the incoming instruction word into a bundle. This is combinational.
    // An illegal encoding keeps only pc and the register indices. Every other
    // field is cleared so that the EXU has no side effect to act on.
    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rs1      = in_inst[19:15];
        dec.rs2      = in_inst[24:20];
        dec.rd       = in_inst[11:7];
        unique case (opcode)
            OPC_OP_IMM: begin
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.imm     = imm_i;
                unique case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op  = ALU_SLL;
                        dec.illegal = (shift_f7 != 7'b0000000);
                    end
                    default: begin
                        dec.alu_op  = in_inst[30] ? ALU_SRA : ALU_SRL;
                        dec.illegal = (shift_f7 != 7'b0000000) && (shift_f7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                dec.reg_wen = 1'b1;
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b001:  dec.alu_op = ALU_SLL;
                        3'b010:  dec.alu_op = ALU_SLT;
                        3'b011:  dec.alu_op = ALU_SLTU;
                        3'b100:  dec.alu_op = ALU_XOR;
                        3'b101:  dec.alu_op = ALU_SRL;
                        3'b110:  dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.alu_op  = ALU_LUI;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.imm     = imm_u;
            end
            OPC_AUIPC: begin
                dec.alu_op  = ALU_AUIPC;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.imm     = imm_u;
            end
            OPC_JAL: begin
                dec.alu_op  = ALU_JAL;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.jump_en = 1'b1;
                dec.imm     = imm_j;
            end
            OPC_JALR: begin
                dec.alu_op  = ALU_JALR;
                dec.alu_src = 1'b1;
                dec.reg_wen = 1'b1;
                dec.jump_en = 1'b1;
                dec.imm     = imm_i;
                dec.illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.alu_op  = ALU_SUB;
                dec.br_en   = 1'b1;
                dec.br_type = funct3;
                dec.imm     = imm_b;
                dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.mem_ren  = 1'b1;
                dec.mem_size = funct3;
                dec.imm      = imm_i;
                unique case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.illegal = 1'b0;
                    3'b011, 3'b110: dec.illegal = (XLEN != 64);
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.mem_wen  = 1'b1;
                dec.mem_size = funct3;
                dec.imm      = imm_s;
                unique case (funct3)
                    3'b000, 3'b001, 3'b010: dec.illegal = 1'b0;
                    3'b011: dec.illegal = (XLEN != 64);
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                dec.ebreak  = (in_inst == INST_EBREAK);
                dec.illegal = (in_inst != INST_EBREAK);
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.illegal) begin
            dec.imm      = '0;
            dec.alu_op   = ALU_ADD;
            dec.alu_src  = 1'b0;
            dec.reg_wen  = 1'b0;
            dec.jump_en  = 1'b0;
            dec.br_en    = 1'b0;
            dec.br_type  = 3'b000;
            dec.mem_ren  = 1'b0;
            dec.mem_wen  = 1'b0;
            dec.mem_size = 3'b000;
            dec.ebreak   = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_wen = 1'b0;
        end
    end

    // Two-entry FIFO built from the output register and one skid slot. A new
    // bundle goes to the output whenever the output is empty or draining.
    // Otherwise it goes to the skid slot, which refills the output first.
    // Flush wins over every transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    // Count bundles that the EXU has taken. A flushed cycle never counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (!flush && drain) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_imm      = out_q.imm;
    assign out_alu_op   = out_q.alu_op;
    assign out_alu_src  = out_q.alu_src;
    assign out_reg_wen  = out_q.reg_wen;
    assign out_jump_en  = out_q.jump_en;
    assign out_br_en    = out_q.br_en;
    assign out_br_type  = out_q.br_type;
    assign out_mem_ren  = out_q.mem_ren;
    assign out_mem_wen  = out_q.mem_wen;
    assign out_mem_size = out_q.mem_size;
    assign out_ebreak   = out_q.ebreak;
    assign out_illegal  = out_q.illegal;
    assign dec_count    = count_q;

endmodule
